// File: rtl/min_scan_pkg.sv
// Shared types and constants for the min_scan_master accelerator: FSM states,
// result-window size and the byte packing used for the result window.
package min_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int          RES_WORDS = 8;
    localparam logic [31:0] MIN_INIT  = 32'h7FFF_FFFF;

    // Result word k carries one byte, LS byte first: k=0..3 from the minimum, k=4..7 from its index.
    function automatic logic [31:0] result_word(input logic [2:0]  k,
                                                input logic [31:0] mv,
                                                input logic [31:0] mi);
        logic [31:0] src;
        logic [7:0]  b;
        src = k[2] ? mi : mv;
        b   = src[{k[1:0], 3'b000} +: 8];
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/min_scan_master_if.sv
// Single-port word-addressed data memory bus between the scan master and the memory.
interface min_scan_master_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readdata;

    modport master (
        output address, writedata, memRead, memWrite,
        input  readdata
    );

    modport slave (
        input  address, writedata, memRead, memWrite,
        output readdata
    );
endinterface

// File: rtl/min_scan_master_min_tracker.sv
// Running signed minimum and its index; index 0 always loads, later elements
// replace the minimum only when strictly smaller so ties keep the first one.
module min_tracker
    import min_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [31:0] idx,
    output logic [31:0] min_val,
    output logic [31:0] min_idx
);

    logic [31:0] min_val_q, min_val_d;
    logic [31:0] min_idx_q, min_idx_d;

    // NOTE: every variable gets its hold value first so no path through always_comb infers a latch.
    always_comb begin
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;
        if (clear) begin
            min_val_d = MIN_INIT;
            min_idx_d = '0;
        end else if (en && (idx == '0 || $signed(data) < $signed(min_val_q))) begin
            min_val_d = data;
            min_idx_d = idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_val_q <= '0;
            min_idx_q <= '0;
        end else begin
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign min_val = min_val_q;
    assign min_idx = min_idx_q;

endmodule

// File: rtl/min_scan_master.sv
// Memory-side accelerator: scans ARRAY_LEN words from ARRAY_BASE for the signed
// minimum, then writes value and index bytewise into the 8-word window at RES_BASE.
module min_scan_master
    import min_scan_pkg::*;
#(
    parameter logic [31:0] ARRAY_BASE = 32'd1000,
    parameter int          ARRAY_LEN  = 20,
    parameter logic [31:0] RES_BASE   = 32'd2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               min_val,
    output logic [31:0]               min_idx,
    min_scan_master_if.master         mem
);

    if (ARRAY_LEN < 1) begin : g_bad_len
        $error("min_scan_master: ARRAY_LEN must be at least 1");
    end

    localparam logic [31:0] LAST_IDX = 32'(ARRAY_LEN - 1);
    localparam logic [2:0]  LAST_RES = 3'(RES_WORDS - 1);

    state_e      state_q, state_d;
    logic [31:0] i_q, i_d;
    logic [2:0]  k_q, k_d;
    logic        trk_clear;
    logic        trk_en;

    min_tracker u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (trk_clear),
        .en      (trk_en),
        .data    (mem.readdata),
        .idx     (i_q),
        .min_val (min_val),
        .min_idx (min_idx)
    );

    // Bus outputs decode from registered state only; start and readdata feed registers, never outputs.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        k_d           = k_q;
        trk_clear     = 1'b0;
        trk_en        = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mem.address   = '0;
        mem.writedata = '0;
        mem.memRead   = 1'b0;
        mem.memWrite  = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = READ;
                    i_d       = '0;
                    trk_clear = 1'b1;
                end
            end
            READ: begin
                mem.address = ARRAY_BASE + i_q;
                mem.memRead = 1'b1;
                trk_en      = 1'b1;
                if (i_q == LAST_IDX) begin
                    state_d = WRITE;
                    k_d     = '0;
                end else begin
                    i_d = i_q + 32'd1;
                end
            end
            WRITE: begin
                mem.address   = RES_BASE + {29'd0, k_q};
                mem.writedata = result_word(k_q, min_val, min_idx);
                mem.memWrite  = 1'b1;
                if (k_q == LAST_RES) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_min_scan_master.sv
// Self-checking bench: four scan masters with different array lengths share one
// clock, each backed by its own behavioural memory; results are checked against a reference model.
module tb_min_scan_master;

    localparam int NDUT = 4;

    function automatic int len_of(input int g);
        case (g)
            0:       return 5;
            1:       return 4;
            2:       return 1;
            default: return 300;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start     [NDUT];
    logic        busy      [NDUT];
    logic        done      [NDUT];
    logic [31:0] min_val   [NDUT];
    logic [31:0] min_idx   [NDUT];
    logic [31:0] addr_w    [NDUT];
    logic [31:0] wd_w      [NDUT];
    logic        rd_w      [NDUT];
    logic        we_w      [NDUT];

    logic [31:0] mem       [NDUT][2048];
    int          rd_cnt    [NDUT];
    int          wr_cnt    [NDUT];
    int          done_cnt  [NDUT];
    logic        cnt_clr   = 1'b0;
    logic        load_en   = 1'b0;
    int          load_sel  = 0;
    logic [10:0] load_addr = '0;
    logic [31:0] load_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LEN_G = (g == 0) ? 5 : (g == 1) ? 4 : (g == 2) ? 1 : 300;
        min_scan_master_if bus ();

        assign addr_w[g]    = bus.address;
        assign wd_w[g]      = bus.writedata;
        assign rd_w[g]      = bus.memRead;
        assign we_w[g]      = bus.memWrite;
        assign bus.readdata = bus.memRead ? mem[g][bus.address[10:0]] : 32'd0;

        min_scan_master #(
            .ARRAY_BASE (32'd1000),
            .ARRAY_LEN  (LEN_G),
            .RES_BASE   (32'd2000)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .min_val (min_val[g]),
            .min_idx (min_idx[g]),
            .mem     (bus)
        );
    end

    always @(posedge clk) begin
        if (load_en) mem[load_sel][load_addr] <= load_data;
        for (int n = 0; n < NDUT; n++) begin
            if (we_w[n]) mem[n][addr_w[n][10:0]] <= wd_w[n];
            if (cnt_clr) begin
                rd_cnt[n]   <= 0;
                wr_cnt[n]   <= 0;
                done_cnt[n] <= 0;
            end else begin
                if (rd_w[n]) rd_cnt[n]   <= rd_cnt[n] + 1;
                if (we_w[n]) wr_cnt[n]   <= wr_cnt[n] + 1;
                if (done[n]) done_cnt[n] <= done_cnt[n] + 1;
            end
        end
    end

    // Reference: first occurrence of the smallest signed value.
    function automatic void ref_min(input logic [31:0] a[$], output logic [31:0] mv, output logic [31:0] mi);
        mv = a[0];
        mi = 0;
        for (int j = 1; j < a.size(); j++) begin
            if ($signed(a[j]) < $signed(mv)) begin
                mv = a[j];
                mi = 32'(j);
            end
        end
    endfunction

    function automatic logic [31:0] ref_word(input int j, input logic [31:0] mv, input logic [31:0] mi);
        if (j < 4) return (mv >> (8 * j)) & 32'hFF;
        return (mi >> (8 * (j - 4))) & 32'hFF;
    endfunction

    task automatic load_word(input int n, input int addr, input logic [31:0] data);
        load_sel  = n;
        load_addr = 11'(addr);
        load_data = data;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    // Pulses start for one cycle and returns the cycle in which done was seen, or -1 on timeout.
    task automatic launch_and_wait(input int n, input int budget, output int cyc);
        start[n] = 1'b1;
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start[n] = 1'b0;
            if (done[n] === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic do_scan(input int n, input logic [31:0] a[$], input string tag);
        logic [31:0] mv, mi, exp_w;
        int cyc;
        ref_min(a, mv, mi);
        for (int j = 0; j < a.size(); j++) load_word(n, 1000 + j, a[j]);
        clear_counts();
        launch_and_wait(n, 1000, cyc);
        total++;
        if (cyc !== len_of(n) + 9) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, len_of(n) + 9);
        end
        total++;
        if (min_val[n] !== mv) begin
            bad++;
            $display("FAIL %s min_val: got %h want %h", tag, min_val[n], mv);
        end
        total++;
        if (min_idx[n] !== mi) begin
            bad++;
            $display("FAIL %s min_idx: got %0d want %0d", tag, min_idx[n], mi);
        end
        total++;
        if (rd_cnt[n] !== len_of(n) || wr_cnt[n] !== 8) begin
            bad++;
            $display("FAIL %s bus_counts: got rd=%0d wr=%0d want rd=%0d wr=8", tag, rd_cnt[n], wr_cnt[n], len_of(n));
        end
        for (int j = 0; j < 8; j++) begin
            exp_w = ref_word(j, mv, mi);
            total++;
            if (mem[n][2000 + j] !== exp_w) begin
                bad++;
                $display("FAIL %s res_word[%0d]: got %h want %h", tag, j, mem[n][2000 + j], exp_w);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_counts();
        rst = 1'b0;
        @(negedge clk);
        for (int n = 0; n < NDUT; n++) begin
            total++;
            if ({busy[n], done[n], rd_w[n], we_w[n]} !== 4'b0 || min_val[n] !== 32'd0 ||
                min_idx[n] !== 32'd0 || addr_w[n] !== 32'd0 || wd_w[n] !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b rd=%b we=%b mv=%h mi=%h addr=%h wd=%h want all 0",
                         n, busy[n], done[n], rd_w[n], we_w[n], min_val[n], min_idx[n], addr_w[n], wd_w[n]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] a[$];
        a = '{32'd5, 32'd3, 32'd9, 32'd3, 32'd7};
        do_scan(0, a, "basic");
        total++;
        if (min_val[0] !== 32'd3 || min_idx[0] !== 32'd1) begin
            bad++;
            $display("FAIL basic_const: got %0d@%0d want 3@1", min_val[0], min_idx[0]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (min_val[0] !== 32'd3 || min_idx[0] !== 32'd1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got %0d@%0d busy=%b want 3@1 busy=0", min_val[0], min_idx[0], busy[0]);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a[$];
        a = '{32'h0000_0010, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF};
        do_scan(1, a, "signed");
        total++;
        if (mem[1][2003] !== 32'h80 || min_idx[1] !== 32'd2) begin
            bad++;
            $display("FAIL signed_const: got byte3=%h idx=%0d want 80 idx=2", mem[1][2003], min_idx[1]);
        end
    endtask

    task automatic test_single();
        logic [31:0] a[$];
        a = '{32'h7FFF_FFFF};
        do_scan(2, a, "single");
    endtask

    task automatic test_big_index();
        logic [31:0] a[$];
        for (int j = 0; j < 300; j++) a.push_back((j == 258) ? 32'hFFFF_FF00 : 32'($urandom_range(0, 32'h7FFF_FFFF)));
        do_scan(3, a, "big_index");
        total++;
        if (mem[3][2004] !== 32'h02 || mem[3][2005] !== 32'h01 || mem[3][2001] !== 32'hFF) begin
            bad++;
            $display("FAIL big_index_bytes: got %h %h %h want 02 01 ff", mem[3][2004], mem[3][2005], mem[3][2001]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a[$];
        for (int it = 0; it < 6; it++) begin
            a.delete();
            for (int j = 0; j < 5; j++)
                a.push_back(it[0] ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom);
            do_scan(0, a, $sformatf("random%0d", it));
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a[$];
        a = '{32'd8, 32'd6, 32'd4, 32'd2, 32'd9};
        for (int j = 0; j < 5; j++) load_word(0, 1000 + j, a[j]);
        clear_counts();
        start[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start[0] = (c == 3 || c == 7);
        end
        start[0] = 1'b0;
        total++;
        if (done_cnt[0] !== 1 || wr_cnt[0] !== 8 || rd_cnt[0] !== 5) begin
            bad++;
            $display("FAIL start_ignored: got done=%0d wr=%0d rd=%0d want 1 8 5", done_cnt[0], wr_cnt[0], rd_cnt[0]);
        end
        total++;
        if (min_val[0] !== 32'd2 || min_idx[0] !== 32'd3) begin
            bad++;
            $display("FAIL start_ignored_result: got %0d@%0d want 2@3", min_val[0], min_idx[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a[$];
        a = '{32'd40, 32'd30, 32'd50, 32'd20, 32'd60};
        for (int j = 0; j < 8; j++) load_word(0, 2000 + j, 32'hA5A5_0000 + 32'(j));
        for (int j = 0; j < 5; j++) load_word(0, 1000 + j, a[j]);
        start[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        total++;
        if (we_w[0] !== 1'b1 || addr_w[0] !== 32'd2003) begin
            bad++;
            $display("FAIL rst_mid_pre: got we=%b addr=%0d want 1 2003", we_w[0], addr_w[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (we_w[0] !== 1'b0 || busy[0] !== 1'b0 || min_val[0] !== 32'd0 || min_idx[0] !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_post: got we=%b busy=%b mv=%h mi=%h want 0 0 0 0", we_w[0], busy[0], min_val[0], min_idx[0]);
        end
        for (int j = 4; j < 8; j++) begin
            total++;
            if (mem[0][2000 + j] !== 32'hA5A5_0000 + 32'(j)) begin
                bad++;
                $display("FAIL rst_mid_keep[%0d]: got %h want %h", j, mem[0][2000 + j], 32'hA5A5_0000 + 32'(j));
            end
        end
        total++;
        if (mem[0][2000] !== 32'd20) begin
            bad++;
            $display("FAIL rst_mid_written: got %h want 00000014", mem[0][2000]);
        end
        do_scan(0, a, "after_rst");
    endtask

    task automatic test_hold_start();
        int c1, c2;
        load_word(2, 1000, 32'hFFFF_FFF0);
        clear_counts();
        start[2] = 1'b1;
        c1 = -1;
        c2 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done[2] === 1'b1) begin
                if (c1 < 0) c1 = c;
                else begin
                    c2 = c;
                    start[2] = 1'b0;
                    break;
                end
            end
        end
        start[2] = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (c1 !== 10 || c2 !== 21) begin
            bad++;
            $display("FAIL hold_start: got done at %0d,%0d want 10,21", c1, c2);
        end
        total++;
        if (done_cnt[2] !== 2 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL hold_start_stop: got done_cnt=%0d busy=%b want 2 0", done_cnt[2], busy[2]);
        end
    endtask

    initial begin
        for (int n = 0; n < NDUT; n++) start[n] = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_single();
        test_big_index();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_hold_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
